reg_bank_wr32: RTL and testbench
================================

// Module: reg_bank_wr32
// PURPOSE
//  Write side of the 32-entry register bank: decodes a 5-bit write address into 32 registers,
//  with byte-enable merge and a sequenced bank clear. Exposes all entries as a flat bus that
//  feeds the 32-to-1 read-select mux I0..I31, which forms the read side.
//  Valid/ready write port; per-entry dirty flags for debug/scoreboard.
// PARAMETERS
//  DW        32   data width per entry (multiple of 8)
//  AW        5    address width; NREG = 2**AW = 32 entries
//  ZERO_REG0 1    1: entry 0 is constant RST_VAL, writes to it ignored, dirty[0] stays 0
//  RST_VAL   0    DW-bit value loaded at reset and by clear
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous, active-low reset
//  wr_valid  in   1        write request
//  wr_ready  out  1        bank can accept a write
//  wr_addr   in   AW       target entry
//  wr_data   in   DW       write data
//  wr_be     in   DW/8     byte enables, bit k -> wr_data[8k+7:8k]
//  clr_req   in   1        request clear of all entries (level, sampled in IDLE)
//  clr_busy  out  1        clear sweep in progress
//  q_flat    out  NREG*DW  entry i on q_flat[i*DW +: DW]; slices drive read-mux I0..I31
//  dirty     out  NREG     bit i set = entry i written since reset/clear
// BEHAVIOUR
//  Reset (async, rst_n=0): all entries = RST_VAL, dirty = 0, state IDLE, cnt = 0;
//   hence wr_ready = 1, clr_busy = 0. Deassertion is synchronised outside this block.
//  FSM: IDLE, CLEAR. wr_ready = (state==IDLE); clr_busy = (state==CLEAR); both decoded from state.
//  Write: accepted on a rising edge with wr_valid && wr_ready. Byte k of entry wr_addr is
//   replaced where wr_be[k]=1; other bytes are kept. q_flat is driven straight from the
//   registers: the new value is visible the cycle after acceptance (1-cycle latency).
//  dirty[wr_addr] set on an accepted write with wr_be != 0. wr_be == 0 is accepted as a no-op:
//   no data change, no dirty change.
//  ZERO_REG0=1 and wr_addr == 0: write accepted (handshake completes), no effect.
//  Upstream keeps wr_addr/data/be stable while wr_valid && !wr_ready. A write is never dropped.
//  IDLE -> CLEAR when clr_req = 1 at an edge; cnt = 0.
//  CLEAR: each cycle entry[cnt] = RST_VAL and dirty[cnt] = 0, then cnt++.
//   At cnt == NREG-1 the entry is cleared and state -> IDLE; the sweep lasts exactly NREG cycles.
//   cnt wraps to 0. clr_req is ignored in CLEAR. Writes stall because wr_ready = 0.
//  Simultaneous wr_valid and clr_req in IDLE: the write commits on that edge and state -> CLEAR.
//   The sweep later overwrites that entry as well.
//  Reset during CLEAR: sweep aborts immediately and the full reset values apply.
//  Widths: cnt is AW bits; merge is per byte with no arithmetic; no X propagates from
//   unselected entries.
// STRUCTURE
//  Package reg_bank_pkg: AW, DW, NREG, RST_VAL, state encoding (IDLE=1'b0, CLEAR=1'b1),
//   BE_W = DW/8.
//  One sub-module, byte_merge: old, new, be -> merged word; purely combinational.
//  Top level holds the FSM, cnt, the address decode (one-hot wr_sel[NREG-1:0]), the entry
//   array and the dirty vector.
// TESTING
//  1 Reset: rst_n=0 with clk running -> every q_flat slice = 0, dirty = 0, wr_ready = 1,
//    clr_busy = 0.
//  2 Full write: addr 5, data 32'hDEAD_BEEF, be 4'hF -> next cycle slice 5 = DEAD_BEEF,
//    dirty = 32'h20. Then addr 5, data 32'h1122_3344, be 4'b0101 -> slice 5 = DE22_BE44.
//  3 Entry 0: addr 0, data FFFF_FFFF, be F -> handshake completes, slice 0 = 0, dirty[0] = 0.
//    be = 0 to addr 7 -> slice 7 and dirty[7] unchanged.
//  4 Clear: fill all 32 entries with their index, then pulse clr_req -> clr_busy high for
//    exactly 32 cycles and wr_ready low for the same cycles. A write held valid during the
//    sweep completes on the first cycle after it ends. All slices = 0 after the sweep except
//    that write; dirty = only that bit.
//  5 Collision: wr_valid (addr 31, data 0xA5A5_A5A5) and clr_req on the same edge -> write
//    commits, slice 31 = A5A5_A5A5 during the first sweep cycles, then 0 after the sweep.
//  6 Reset mid-clear: assert rst_n=0 at sweep cycle 10 -> asynchronous return to reset
//    values; after release clr_busy = 0 and the next write is accepted immediately.

Source files
------------

// File: rtl/reg_bank_wr32_pkg.sv
// Shared widths, reset value and FSM encoding for the write side of the register bank.
package reg_bank_pkg;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned BE_W = DW / 8;

  localparam logic [DW-1:0] RST_VAL = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_bank_wr32_if.sv
// Valid/ready write port of the register bank.
//   wr_valid  master->slave  write request
//   wr_ready  slave->master  bank can accept a write
//   wr_addr   master->slave  target entry
//   wr_data   master->slave  write data
//   wr_be     master->slave  byte enables, bit k covers wr_data[8k+7:8k]
interface reg_bank_wr32_if
  import reg_bank_pkg::*;
#(
  parameter int unsigned AW = reg_bank_pkg::AW,
  parameter int unsigned DW = reg_bank_pkg::DW
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_be;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_be,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_be,
    output wr_ready
  );

endinterface

// File: rtl/reg_bank_wr32_byte_merge.sv
// Per-byte merge of a new word into an old word; purely combinational.
//   old_word  in   DW    current entry contents
//   new_word  in   DW    incoming write data
//   be        in   DW/8  byte k taken from new_word when be[k] = 1
//   merged_c  out  DW    merged word
module byte_merge
  import reg_bank_pkg::*;
#(
  parameter int unsigned DW = reg_bank_pkg::DW
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   merged_c
);

  localparam int unsigned NB = DW / 8;

  always_comb begin
    merged_c = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) begin
        merged_c[8*k +: 8] = new_word[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_bank_wr32.sv
// Write side of the 32-entry register bank: address decode, byte-enable merge,
// sequenced bank clear and per-entry dirty flags. All entries are exposed flat
// for the downstream 32-to-1 read-select mux.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   wr        if   valid/ready write port (slave side)
//   clr_req   in   level request to clear every entry, sampled in IDLE
//   clr_busy  out  clear sweep in progress
//   q_flat    out  entry i on q_flat[i*DW +: DW]
//   dirty     out  bit i set when entry i was written since reset/clear
module reg_bank_wr32
  import reg_bank_pkg::*;
#(
  parameter int unsigned    DW        = reg_bank_pkg::DW,
  parameter int unsigned    AW        = reg_bank_pkg::AW,
  parameter bit             ZERO_REG0 = 1'b1,
  parameter logic [DW-1:0]  RST_VAL   = DW'(reg_bank_pkg::RST_VAL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  reg_bank_wr32_if.slave           wr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic [(2**AW)*DW-1:0]    q_flat,
  output logic [(2**AW)-1:0]       dirty
);

  localparam int unsigned NREG = 2 ** AW;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             wr_fire;
  logic [NREG-1:0]  wr_sel;
  logic [NREG-1:0]  wr_hit;
  logic [NREG-1:0]  clr_hit;
  logic [DW-1:0]    old_word;
  logic [DW-1:0]    merged_word;

  // State and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the sweep visits every entry once and ends on the last index
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    wr.wr_ready = 1'b0;
    clr_busy    = 1'b0;
    case (state_q)
      IDLE:    wr.wr_ready = 1'b1;
      CLEAR:   clr_busy    = 1'b1;
      default: begin
        wr.wr_ready = 1'b0;
        clr_busy    = 1'b0;
      end
    endcase
  end

  // Write only in IDLE; a simultaneous clr_req still lets this write commit
  assign wr_fire = wr.wr_valid && (state_q == IDLE);
  assign wr_sel  = NREG'(1) << wr.wr_addr;
  assign wr_hit  = (wr_fire && (|wr.wr_be)) ? wr_sel : '0;
  assign clr_hit = (state_q == CLEAR) ? (NREG'(1) << cnt_q) : '0;

  // Current contents of the addressed entry, selected without variable part-selects
  always_comb begin
    old_word = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (wr_sel[i]) begin
        old_word = q_flat[i*DW +: DW];
      end
    end
  end

  byte_merge #(
    .DW (DW)
  ) u_merge (
    .old_word (old_word),
    .new_word (wr.wr_data),
    .be       (wr.wr_be),
    .merged_c (merged_word)
  );

  // Entry array; entry 0 may be hard-wired to the reset value
  for (genvar i = 0; i < NREG; i++) begin : g_ent
    if (ZERO_REG0 && (i == 0)) begin : g_const
      assign q_flat[i*DW +: DW] = RST_VAL;
      assign dirty[i]           = 1'b0;
    end else begin : g_reg
      logic [DW-1:0] ent_q;
      logic          dirty_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ent_q   <= RST_VAL;
          dirty_q <= 1'b0;
        end else if (clr_hit[i]) begin
          ent_q   <= RST_VAL;
          dirty_q <= 1'b0;
        end else if (wr_hit[i]) begin
          ent_q   <= merged_word;
          dirty_q <= 1'b1;
        end
      end

      assign q_flat[i*DW +: DW] = ent_q;
      assign dirty[i]           = dirty_q;
    end
  end

endmodule

// File: tb/tb_reg_bank_wr32.sv
// Scoreboard bench for reg_bank_wr32: the stimulus pushes the expected entry value and
// dirty vector for every write it issues; the monitor pops and compares on each accepted
// write, one cycle later. Sweep timing and post-sweep contents are checked inline.
module tb_reg_bank_wr32;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr_req = 1'b0;
  logic                 clr_busy;
  logic [NREG*DW-1:0]   q_flat;
  logic [NREG-1:0]      dirty;

  reg_bank_wr32_if #(.AW(AW), .DW(DW)) bus ();

  reg_bank_wr32 #(
    .DW        (DW),
    .AW        (AW),
    .ZERO_REG0 (1'b1),
    .RST_VAL   ('0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (bus),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .q_flat   (q_flat),
    .dirty    (dirty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] val;
    logic [31:0] dirty;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   fire_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int i);
    return q_flat[i*DW +: DW];
  endfunction

  // Monitor: every accepted write is compared against the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    if (rst_n && bus.wr_valid && bus.wr_ready) begin
      fire_cnt++;
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d accepted with no expectation queued", bus.wr_addr);
      end else begin
        e = exp_q.pop_front();
        check32($sformatf("wr_slice[%0d]", e.addr), slice(e.addr), e.val);
        check32($sformatf("wr_dirty@%0d", e.addr), dirty, e.dirty);
      end
    end
  end

  // Issue one write and wait (bounded) for its acceptance; waited = negedges until accepted
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] ev, input logic [31:0] ed, output int waited);
    int start;
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_be    = be;
    exp_q.push_back('{int'(a), ev, ed});
    start  = fire_cnt;
    waited = 0;
    while (fire_cnt == start && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (fire_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: addr %0d not accepted, got 0 accepts expected 1", a);
      void'(exp_q.pop_back());
    end
    bus.wr_valid = 1'b0;
  endtask

  // Count negedges with the sweep active (bounded)
  task automatic count_sweep(output int busy, output int ready_bad);
    busy      = 0;
    ready_bad = 0;
    while (clr_busy && busy < 100) begin
      if (bus.wr_ready) ready_bad++;
      busy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          w;
    int          busy;
    int          rbad;
    int          start;
    logic [31:0] md;

    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_be    = '0;

    // Reset values with clock running
    repeat (3) @(negedge clk);
    check32("rst_q_flat", {31'b0, |q_flat}, 32'h0);
    check32("rst_dirty", dirty, 32'h0);
    check32("rst_wr_ready", {31'b0, bus.wr_ready}, 32'h1);
    check32("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full write then partial byte-enable merge
    do_write(5'd5, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 32'h0000_0020, w);
    check32("first_wr_latency", 32'(w), 32'd1);
    do_write(5'd5, 32'h1122_3344, 4'b0101, 32'hDE22_BE44, 32'h0000_0020, w);

    // Entry 0 is constant; be == 0 is a no-op
    do_write(5'd0, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0000_0020, w);
    do_write(5'd7, 32'h1234_5678, 4'h0, 32'h0, 32'h0000_0020, w);
    check32("slice5_kept", slice(5), 32'hDE22_BE44);

    // Fill every entry with its index
    md = 32'h0000_0020;
    for (int i = 0; i < int'(NREG); i++) begin
      if (i != 0) md[i] = 1'b1;
      do_write(5'(i), 32'(i), 4'hF, (i == 0) ? 32'h0 : 32'(i), md, w);
    end
    check32("fill_dirty", dirty, 32'hFFFF_FFFE);

    // Clear sweep with a write held valid across it
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req      = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd9;
    bus.wr_data  = 32'h9999_0009;
    bus.wr_be    = 4'hF;
    exp_q.push_back('{9, 32'h9999_0009, 32'h0000_0200});
    start = fire_cnt;
    count_sweep(busy, rbad);
    check32("clr_busy_cycles", 32'(busy), 32'd32);
    check32("wr_ready_low_in_sweep", 32'(rbad), 32'd0);
    check32("no_write_during_sweep", 32'(fire_cnt - start), 32'd0);
    @(negedge clk);
    check32("held_write_after_sweep", 32'(fire_cnt - start), 32'd1);
    bus.wr_valid = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      check32($sformatf("post_clr_slice[%0d]", i), slice(i), (i == 9) ? 32'h9999_0009 : 32'h0);
    end
    check32("post_clr_dirty", dirty, 32'h0000_0200);

    // Write and clr_req on the same edge
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd31;
    bus.wr_data  = 32'hA5A5_A5A5;
    bus.wr_be    = 4'hF;
    clr_req      = 1'b1;
    exp_q.push_back('{31, 32'hA5A5_A5A5, 32'h8000_0200});
    start = fire_cnt;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    clr_req      = 1'b0;
    check32("collision_write_fired", 32'(fire_cnt - start), 32'd1);
    check32("collision_clr_busy", {31'b0, clr_busy}, 32'h1);
    check32("collision_slice31_early", slice(31), 32'hA5A5_A5A5);
    count_sweep(busy, rbad);
    check32("collision_sweep_cycles", 32'(busy), 32'd32);
    check32("collision_slice31_after", slice(31), 32'h0);
    check32("collision_dirty_after", dirty, 32'h0);

    // Reset in the middle of a sweep
    do_write(5'd20, 32'h2020_2020, 4'hF, 32'h2020_2020, 32'h0010_0000, w);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    check32("midclr_busy_before_rst", {31'b0, clr_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check32("midclr_rst_busy", {31'b0, clr_busy}, 32'h0);
    check32("midclr_rst_ready", {31'b0, bus.wr_ready}, 32'h1);
    check32("midclr_rst_dirty", dirty, 32'h0);
    check32("midclr_rst_slice20", slice(20), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd12, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 32'h0000_1000, w);
    check32("post_rst_wr_latency", 32'(w), 32'd1);
    check32("post_rst_clr_busy", {31'b0, clr_busy}, 32'h0);

    repeat (2) @(negedge clk);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
